// File: rtl/ifetch.sv
// Instruction-fetch initiator: drives the PC into a 1-cycle ROM, buffers the
// returned words in a 2-entry FIFO and hands (pc, instr) pairs to decode.
module ifetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] rom_addr,
    input  logic [31:0] rom_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr,
    input  logic        out_ready
);

    localparam int unsigned XLEN  = 32;
    localparam int unsigned DEPTH = 2;
    localparam int unsigned CNT_W = 2;
    localparam int unsigned OCC_W = 3;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    logic [XLEN-1:0]  f_pc_q, f_pc_d;
    logic             req_v_q, req_v_d;
    logic [XLEN-1:0]  req_pc_q, req_pc_d;
    fetch_entry_t     entry_q [DEPTH];
    fetch_entry_t     entry_d [DEPTH];
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic             pop;
    logic             push;
    logic             issue;
    logic [OCC_W-1:0] occ;

    assign rom_addr  = f_pc_q;
    assign out_valid = (count_q != CNT_W'(0));
    assign out_pc    = entry_q[rd_ptr_q].pc;
    assign out_instr = entry_q[rd_ptr_q].instr;

    // Next-state: FIFO push/pop, fetch issue, redirect flush.
    always_comb begin
        f_pc_d   = f_pc_q;
        req_v_d  = req_v_q;
        req_pc_d = req_pc_q;
        entry_d  = entry_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;

        pop  = out_valid && out_ready;
        push = req_v_q;
        // Occupancy once the in-flight word lands; issue only if a slot remains.
        occ     = OCC_W'(count_q) + OCC_W'(req_v_q) - OCC_W'(pop);
        issue   = (occ < OCC_W'(2));
        count_d = CNT_W'(occ);

        if (push) begin
            entry_d[wr_ptr_q] = '{pc: req_pc_q, instr: rom_rdata};
            wr_ptr_d          = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end

        if (issue) begin
            req_v_d  = 1'b1;
            req_pc_d = f_pc_q;
            f_pc_d   = f_pc_q + XLEN'(4);
        end else begin
            req_v_d  = 1'b0;
        end

        // Flush only resets occupancy; stale entries are simply unreachable.
        if (redirect_valid) begin
            f_pc_d   = redirect_pc & ~XLEN'(3);
            req_v_d  = 1'b0;
            count_d  = '0;
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            f_pc_q   <= RESET_PC;
            req_v_q  <= 1'b0;
            req_pc_q <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                entry_q[i] <= '0;
            end
        end else begin
            f_pc_q   <= f_pc_d;
            req_v_q  <= req_v_d;
            req_pc_q <= req_pc_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            entry_q  <= entry_d;
        end
    end

`ifndef SYNTHESIS
    // A returning word must always find a free slot.
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(req_v_q && (count_q == CNT_W'(DEPTH)) && !pop));
`endif

endmodule

// File: tb/tb_ifetch.sv
// Randomized bench for ifetch with an abstract stream/latency reference model.
module tb_ifetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] rom_addr;
    logic [31:0] rom_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        out_ready;

    always #5 clk = ~clk;

    ifetch #(.RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .rst            (rst),
        .rom_addr       (rom_addr),
        .rom_rdata      (rom_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_pc         (out_pc),
        .out_instr      (out_instr),
        .out_ready      (out_ready)
    );

    // 1024-word ROM, mem[i] = A0000000 + i, aliased beyond its depth.
    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return 32'hA000_0000 + 32'(a[11:2]);
    endfunction

    always @(posedge clk) rom_rdata <= rom_word(rom_addr);

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Model: after a restart (reset or redirect) cycle, cycle n=1 issues the
    // target, out_valid is 0 in cycles 1..2 and stays 1 from cycle 3 onward.
    // Each accepted instruction advances the expected head PC by 4; the fetch
    // PC runs ahead of the head by the number of words in flight (0, 1, then 2).
    logic [31:0] exp_pc;
    int          n = 0;
    bit          known = 0;
    bit          from_rst = 0;

    task automatic cycle(input bit r, input bit rdy, input bit rv, input logic [31:0] rpc);
        bit          exp_valid;
        logic [31:0] off;
        rst            = r;
        out_ready      = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        #3;
        if (known) begin
            exp_valid = (n >= 3);
            off = (n >= 3) ? 32'd8 : (n == 2) ? 32'd4 : 32'd0;
            check("rom_addr", rom_addr, exp_pc + off);
            check("out_valid", 32'(out_valid), 32'(exp_valid));
            if (exp_valid) begin
                check("out_pc", out_pc, exp_pc);
                check("out_instr", out_instr, rom_word(exp_pc));
            end else if (from_rst) begin
                check("rst_out_pc", out_pc, 32'h0);
                check("rst_out_instr", out_instr, 32'h0);
            end
        end
        if (r) begin
            exp_pc   = RESET_PC;
            n        = 1;
            from_rst = 1;
            known    = 1;
        end else begin
            if (n >= 3 && rdy) exp_pc = exp_pc + 32'd4;
            if (rv) begin
                exp_pc   = rpc & ~32'h3;
                n        = 1;
                from_rst = 0;
            end else if (n < 3) begin
                n++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset then free-run
        cycle(1, 1, 0, 32'h0);
        cycle(1, 1, 0, 32'h0);
        repeat (10) cycle(0, 1, 0, 32'h0);

        // Back-pressure from the 3rd instruction for 5 cycles
        cycle(1, 1, 0, 32'h0);
        repeat (4) cycle(0, 1, 0, 32'h0);
        repeat (5) cycle(0, 0, 0, 32'h0);
        repeat (6) cycle(0, 1, 0, 32'h0);

        // Redirect mid-stream with two entries buffered
        cycle(0, 0, 0, 32'h0);
        cycle(0, 1, 1, 32'h0000_0103);
        repeat (6) cycle(0, 1, 0, 32'h0);

        // Redirect during stall with simultaneous pop
        repeat (2) cycle(0, 0, 0, 32'h0);
        cycle(0, 1, 1, 32'h0000_0200);
        repeat (6) cycle(0, 1, 0, 32'h0);

        // Back-to-back redirects: last wins
        cycle(0, 1, 1, 32'h0000_0400);
        cycle(0, 1, 1, 32'h0000_0500);
        repeat (5) cycle(0, 1, 0, 32'h0);

        // Reset mid-operation while stalled and full
        repeat (2) cycle(0, 0, 0, 32'h0);
        cycle(1, 1, 1, 32'h0000_0300);
        repeat (8) cycle(0, 1, 0, 32'h0);

        // Wrap-around
        cycle(0, 1, 1, 32'hFFFF_FFF8);
        repeat (8) cycle(0, 1, 0, 32'h0);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            bit          r, rdy, rv;
            logic [31:0] rpc;
            r   = ($urandom_range(99) < 2);
            rdy = ($urandom_range(99) < 65);
            rv  = ($urandom_range(99) < 5);
            rpc = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15)))
                                           : $urandom();
            cycle(r, rdy, rv, rpc);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
